otp_stream_cypher: RTL and testbench
====================================

# otp_stream_cypher

Parametrised one-time-pad stream cypher. Loads a `MSG_W`-bit message, consumes one `KEY_W`-bit key chunk per accepted key handshake, XORs it with the matching message chunk (MSB chunk first), and reassembles the `MSG_W`-bit cyphertext. It has explicit start, key and output handshakes, so key sources and consumers can stall it. It sits between the message source and the transmit path. Because the operation is XOR, the same block also decrypts.

## Interface
- `MSG_W`, default 32: message width in bits. Must be a multiple of `KEY_W`.
- `KEY_W`, default 8: key chunk width in bits.
- `NCHUNK`, derived as `MSG_W/KEY_W`: chunks per message. Must be ≥1.
- `clk`  in  1  clock. Everything is on the rising edge.
- `rst_n`  in  1  reset. Asynchronous and active-low.
- `start`  in  1  load `msg_in`. Honoured only in IDLE.
- `msg_in`  in  `MSG_W`  plaintext, sampled on the cycle `start` is accepted.
- `abort`  in  1  synchronous abandon. Returns the block to IDLE.
- `busy`  out  1  high in RUN and DONE.
- `key_valid`  in  1  key chunk available.
- `key_in`  in  `KEY_W`  key chunk.
- `key_ready`  out  1  high exactly in RUN.
- `out_valid`  out  1  high exactly in DONE.
- `out_ready`  in  1  consumer accepts `cyph_out`.
- `cyph_out`  out  `MSG_W`  cyphertext. Held stable while `out_valid` is high.
- `key_err`  out  1  sticky key-reuse flag. See Configuration.

## Operation
- Key handshake: `key_valid && key_ready` at a rising edge. Output handshake: `out_valid && out_ready` at a rising edge.
- State IDLE: `start` loads `msg_in` into the message shift register, clears the accumulator and sets `cnt=0`, then goes to RUN. Key input is ignored in IDLE.
- State RUN, on each key handshake:
  - `acc <= {acc[MSG_W-KEY_W-1:0], msg_sr[MSG_W-1 -: KEY_W] ^ key_in}`.
  - The message shift register shifts left by `KEY_W`.
  - `cnt` increments.
  - On the handshake with `cnt==NCHUNK-1`, go to DONE.
- State DONE: `cyph_out` equals the accumulator. On an output handshake, go to IDLE.
- Result: the first-processed chunk lands in the MSBs of `cyph_out`.
- `abort` in RUN or DONE goes to IDLE and discards the message and accumulator.
  - If `abort` coincides with a key handshake, that key is treated as consumed and is discarded.
  - If `abort` coincides with an output handshake, both are treated as happened and the next state is IDLE.
  - `abort` in IDLE has no effect.
- `start` is ignored outside IDLE. If `start` and `abort` are both asserted in IDLE, `start` wins.
- With `NCHUNK==1`, one key handshake moves the block directly from RUN to DONE.
- `cnt` is `$clog2(NCHUNK+1)` bits wide. It never wraps within a message.

## Timing
- Reset: state IDLE, and `busy`, `key_ready`, `out_valid`, `cyph_out`, `key_err` are all 0.
- Reset asserted mid-operation drops everything immediately. No partial output is produced.
- `start` accepted at edge T: `busy` and `key_ready` are high from T.
- With `key_valid` held high, key handshakes occur at T+1 … T+NCHUNK.
- `out_valid` rises the cycle after the last key handshake, i.e. after T+NCHUNK.
- Key stalls add cycles one-for-one.
- Minimum message period is `NCHUNK+2` cycles: load, `NCHUNK` chunks, output with `out_ready` already high.
- All outputs are registered or decoded from the state register. There is no combinational path from input to output.

## Configuration
- `OTP_KEY_REUSE_CHK_EN` defined:
  - The block keeps the last accepted key chunk plus a valid bit. Both reset to 0 and persist across messages and aborts.
  - A key handshake whose `key_in` equals the stored chunk, while the valid bit is 1, sets `key_err` one cycle later.
  - `key_err` stays set until reset. Processing continues unchanged.
- Macro undefined: `key_err` is tied to 0 and no comparison logic is built.

## Structure
- Package `otp_pkg` holds:
  - The state typedef `otp_state_t` (`OTP_IDLE`, `OTP_RUN`, `OTP_DONE`).
  - The function `otp_nchunk(msg_w, key_w)`.
  - An elaboration-time check that `MSG_W % KEY_W == 0`.
- One sub-module, `otp_chunk_shifter`: a parallel-load, `KEY_W`-stride left shift register exposing its top chunk. Instantiate it twice: once for the message register and once for the accumulator.

## Test plan
- Encrypt: `MSG_W=32`, `KEY_W=8`, `msg_in=0xDEADBEEF`, keys 0x11, 0x22, 0x33, 0x44 with no stalls → `out_valid` after the fourth key, `cyph_out=0xCF8F8DAB`.
- Decrypt and stall: `msg_in=0xCF8F8DAB`, same keys with `key_valid` low for 3 cycles between chunks → `cyph_out=0xDEADBEEF`.
- Backpressure: hold `out_ready` low for 5 cycles → `cyph_out` stable, `busy` high, `start` pulses ignored; then `out_ready` high → IDLE next cycle.
- Abort: abort after 2 key chunks, then restart with `0x00000000` and keys 0xAA×4 → `cyph_out=0xAAAAAAAA`, with no residue from the aborted message.
- Reset: deassert `rst_n` during RUN and during DONE → all outputs 0 immediately; the next message completes correctly.
- Key reuse (`OTP_KEY_REUSE_CHK_EN`): keys 0x11, 0x11, 0x22, 0x33 → `key_err=1` from the cycle after the second handshake and held; output still `0xCFBC9CDC` for `msg_in=0xDEADBEEF`.

Source files
------------

// File: rtl/otp_pkg.sv
// otp_pkg: state type, chunk-count helper and configuration check for otp_stream_cypher.
package otp_pkg;

    typedef enum logic [1:0] {OTP_IDLE, OTP_RUN, OTP_DONE} otp_state_t;

    function automatic int otp_nchunk(input int msg_w, input int key_w);
        return msg_w / key_w;
    endfunction

    // Elaboration-time guard: the message must split into whole key chunks.
    function automatic bit otp_cfg_ok(input int msg_w, input int key_w);
        return key_w > 0 && msg_w >= key_w && msg_w % key_w == 0;
    endfunction

endpackage

// File: rtl/otp_chunk_shifter.sv
// otp_chunk_shifter: parallel-load register shifting left by one KEY_W chunk, exposing its top chunk.
module otp_chunk_shifter #(
    parameter int W     = 32,
    parameter int KEY_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [W-1:0]     load_val,
    input  logic             shift,
    input  logic [KEY_W-1:0] shift_in,
    output logic [W-1:0]     q,
    output logic [KEY_W-1:0] top
);

    logic [W-1:0] shifted;

    if (W == KEY_W) begin : g_one
        assign shifted = shift_in;
    end else begin : g_many
        assign shifted = {q[W-KEY_W-1:0], shift_in};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     q <= '0;
        else if (load)  q <= load_val;
        else if (shift) q <= shifted;
    end

    assign top = q[W-1 -: KEY_W];

endmodule

// File: rtl/otp_stream_cypher.sv
// otp_stream_cypher: one-time-pad XOR stream cypher with start/key/output handshakes.
// Define OTP_KEY_REUSE_CHK_EN to build the sticky key-reuse detector driving key_err.
module otp_stream_cypher
    import otp_pkg::*;
#(
    parameter int MSG_W = 32,
    parameter int KEY_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [MSG_W-1:0] msg_in,
    input  logic             abort,
    output logic             busy,
    input  logic             key_valid,
    input  logic [KEY_W-1:0] key_in,
    output logic             key_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [MSG_W-1:0] cyph_out,
    output logic             key_err
);

    localparam int NCHUNK = otp_nchunk(MSG_W, KEY_W);
    localparam int CW     = $clog2(NCHUNK + 1);

    if (!otp_cfg_ok(MSG_W, KEY_W)) begin : g_bad_cfg
        $error("otp_stream_cypher: MSG_W must be a non-zero multiple of KEY_W");
    end

    otp_state_t       state, state_nxt;
    logic [CW-1:0]    cnt;
    logic             key_hs, load, clear, last;
    logic [KEY_W-1:0] msg_top, acc_top_unused;
    logic [MSG_W-1:0] acc, msg_q_unused;

    assign key_hs = key_valid && state == OTP_RUN;
    assign load   = start && state == OTP_IDLE;
    // Both registers are wiped on a new load and on abort so no residue survives.
    assign clear  = load || (abort && state != OTP_IDLE);
    assign last   = cnt == CW'(NCHUNK - 1);

    always_comb begin
        state_nxt = state;
        case (state)
            OTP_IDLE: state_nxt = start ? OTP_RUN : OTP_IDLE;
            OTP_RUN:  state_nxt = abort ? OTP_IDLE : (key_hs && last) ? OTP_DONE : OTP_RUN;
            OTP_DONE: state_nxt = (abort || out_ready) ? OTP_IDLE : OTP_DONE;
            default:  state_nxt = OTP_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= OTP_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (load)        cnt <= '0;
            else if (key_hs) cnt <= cnt + CW'(1);
        end
    end

    otp_chunk_shifter #(.W(MSG_W), .KEY_W(KEY_W)) u_msg (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (clear),
        .load_val (load ? msg_in : '0),
        .shift    (key_hs),
        .shift_in ('0),
        .q        (msg_q_unused),
        .top      (msg_top)
    );

    otp_chunk_shifter #(.W(MSG_W), .KEY_W(KEY_W)) u_acc (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (clear),
        .load_val ('0),
        .shift    (key_hs),
        .shift_in (msg_top ^ key_in),
        .q        (acc),
        .top      (acc_top_unused)
    );

    assign busy      = state != OTP_IDLE;
    assign key_ready = state == OTP_RUN;
    assign out_valid = state == OTP_DONE;
    assign cyph_out  = out_valid ? acc : '0;

`ifdef OTP_KEY_REUSE_CHK_EN
    logic [KEY_W-1:0] last_key;
    logic             last_vld;

    // History survives messages and aborts; only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_key <= '0;
            last_vld <= 1'b0;
            key_err  <= 1'b0;
        end else if (key_hs) begin
            key_err  <= key_err | (last_vld && key_in == last_key);
            last_key <= key_in;
            last_vld <= 1'b1;
        end
    end
`else
    assign key_err = 1'b0;
`endif

endmodule

// File: tb/tb_otp_stream_cypher.sv
// tb_otp_stream_cypher: table vectors, hand sequences and random traffic against a word-level pad model.
module tb_otp_stream_cypher;

    logic        clk = 0, rst_n = 0, start = 0, abort = 0, key_valid = 0, out_ready = 0;
    logic [31:0] msg_in = 0;
    logic [7:0]  key_in = 0;
    logic        busy, key_ready, out_valid, key_err;
    logic [31:0] cyph_out;
    int          checks = 0, errors = 0;

    // Model: phase 0 idle, 1 collecting keys, 2 result ready; pad is the key bytes as one word.
    int          m_st = 0, m_n = 0;
    logic [31:0] m_msg = 0, m_pad = 0;
    logic        m_err = 0, m_lastv = 0;
    logic [7:0]  m_last = 0;

    typedef struct {
        logic [31:0] msg;
        logic [31:0] keys;
        int          stall;
        int          hold;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[4];

    otp_stream_cypher #(.MSG_W(32), .KEY_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .msg_in    (msg_in),
        .abort     (abort),
        .busy      (busy),
        .key_valid (key_valid),
        .key_in    (key_in),
        .key_ready (key_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .cyph_out  (cyph_out),
        .key_err   (key_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        case (m_st)
            0: if (start) begin
                m_st = 1; m_msg = msg_in; m_pad = 0; m_n = 0;
            end
            1: begin
                if (key_valid) begin
`ifdef OTP_KEY_REUSE_CHK_EN
                    if (m_lastv && key_in == m_last) m_err = 1;
                    m_last = key_in; m_lastv = 1;
`endif
                    m_pad = (m_pad << 8) | 32'(key_in);
                    m_n++;
                end
                if (abort) m_st = 0;
                else if (m_n == 4) m_st = 2;
            end
            default: if (abort || out_ready) m_st = 0;
        endcase
    endtask

    task automatic check_all();
        chk("busy", 32'(busy), 32'(m_st != 0));
        chk("key_ready", 32'(key_ready), 32'(m_st == 1));
        chk("out_valid", 32'(out_valid), 32'(m_st == 2));
        chk("cyph_out", cyph_out, m_st == 2 ? m_msg ^ m_pad : 32'h0);
        chk("key_err", 32'(key_err), 32'(m_err));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic start_msg(input logic [31:0] m);
        start = 1; msg_in = m;
        tick();
        start = 0;
    endtask

    task automatic feed(input logic [31:0] kw, input int n, input int stall);
        for (int i = 0; i < n; i++) begin
            key_valid = 1; key_in = kw[31-8*i -: 8];
            tick();
            key_valid = 0;
            if (i < n - 1) repeat (stall) tick();
        end
    endtask

    task automatic run_vec(input vec_t v);
        start_msg(v.msg);
        feed(v.keys, 4, v.stall);
        chk("tbl_cyph", cyph_out, v.exp);
        chk("tbl_valid", 32'(out_valid), 32'h1);
        for (int i = 0; i < v.hold; i++) begin
            start = i[0]; msg_in = 32'h12345678;
            tick();
            chk("tbl_hold_cyph", cyph_out, v.exp);
            chk("tbl_hold_busy", 32'(busy), 32'h1);
        end
        start = 0; out_ready = 1;
        tick();
        out_ready = 0;
        chk("tbl_idle", 32'(busy), 32'h0);
    endtask

    task automatic reset_mid();
        #2 rst_n = 0;
        #1;
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_key_ready", 32'(key_ready), 32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_cyph", cyph_out, 32'h0);
        chk("rst_key_err", 32'(key_err), 32'h0);
        m_st = 0; m_err = 0; m_lastv = 0; m_last = 0;
        start = 0; abort = 0; key_valid = 0; out_ready = 0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1;
    endtask

    initial begin
        vecs[0] = '{32'hDEADBEEF, 32'h11223344, 0, 0, 32'hCF8F8DAB};
        vecs[1] = '{32'hCF8F8DAB, 32'h11223344, 3, 0, 32'hDEADBEEF};
        vecs[2] = '{32'hDEADBEEF, 32'h11112233, 0, 5, 32'hCFBC9CDC};
        vecs[3] = '{32'h00000000, 32'hAAAAAAAA, 1, 2, 32'hAAAAAAAA};

        @(negedge clk);
        check_all();
        rst_n = 1;

        for (int i = 0; i < 3; i++) run_vec(vecs[i]);
`ifdef OTP_KEY_REUSE_CHK_EN
        chk("reuse_sticky", 32'(key_err), 32'h1);
`endif

        // Abort after two chunks, then a clean message must carry no residue.
        start_msg(32'hDEADBEEF);
        feed(32'h11223344, 2, 0);
        abort = 1;
        tick();
        abort = 0;
        run_vec(vecs[3]);

        // Abort together with a key handshake, then together with an output handshake.
        start_msg(32'h01020304);
        feed(32'h55667788, 1, 0);
        abort = 1; key_valid = 1; key_in = 8'h99;
        tick();
        abort = 0; key_valid = 0;
        start_msg(32'h01020304);
        feed(32'h55667788, 4, 0);
        abort = 1; out_ready = 1;
        tick();
        abort = 0; out_ready = 0;
        // Abort alone in idle does nothing; start beats abort in idle.
        abort = 1;
        tick();
        start = 1; msg_in = 32'hCAFEF00D;
        tick();
        start = 0; abort = 0;
        feed(32'h10203040, 4, 2);
        out_ready = 1;
        tick();
        out_ready = 0;

        // Reset during RUN and during DONE.
        start_msg(32'hDEADBEEF);
        feed(32'h11223344, 2, 0);
        reset_mid();
        start_msg(32'hDEADBEEF);
        feed(32'h11223344, 4, 0);
        reset_mid();
        run_vec(vecs[0]);

        for (int c = 0; c < 800; c++) begin
            start     = ($urandom % 4) == 0;
            msg_in    = $urandom;
            key_valid = ($urandom % 3) != 0;
            if (($urandom % 4) != 0) key_in = 8'($urandom);
            out_ready = ($urandom % 2) == 0;
            abort     = ($urandom % 40) == 0;
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
